// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha_pkg
//  Description : Shared definitions for the SHA-2 message schedule streamer:
//                FSM state encoding, legal word-width / round-count pairs and
//                the sigma0 / sigma1 rotate and shift amounts per word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

    // Streamer FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_t;

    // Legal configurations
    localparam int unsigned SHA256_WORD_W = 32;
    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned SHA512_WORD_W = 64;
    localparam int unsigned SHA512_ROUNDS = 80;

    // Round index width on the output port
    localparam int unsigned IDX_W = 7;

    // SHA-256 sigma amounts
    localparam int unsigned S256_S0_ROT_A = 7;
    localparam int unsigned S256_S0_ROT_B = 18;
    localparam int unsigned S256_S0_SHR   = 3;
    localparam int unsigned S256_S1_ROT_A = 17;
    localparam int unsigned S256_S1_ROT_B = 19;
    localparam int unsigned S256_S1_SHR   = 10;

    // SHA-512 sigma amounts
    localparam int unsigned S512_S0_ROT_A = 1;
    localparam int unsigned S512_S0_ROT_B = 8;
    localparam int unsigned S512_S0_SHR   = 7;
    localparam int unsigned S512_S1_ROT_A = 19;
    localparam int unsigned S512_S1_ROT_B = 61;
    localparam int unsigned S512_S1_SHR   = 6;

    // True when the (word width, rounds) pair is a supported configuration
    function automatic bit legal_config(input int unsigned word_w,
                                        input int unsigned rounds);
        return ((word_w == SHA256_WORD_W) && (rounds == SHA256_ROUNDS)) ||
               ((word_w == SHA512_WORD_W) && (rounds == SHA512_ROUNDS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_sigma.sv
`default_nettype none
// ============================================================================
//  Module      : sha_sigma
//  Description : Combinational SHA-2 small sigma functions. The rotate/shift
//                amounts are selected by WORD_W (32 -> SHA-256, 64 -> SHA-512).
//  Ports       : x0     in  WORD_W  operand of sigma0
//                x1     in  WORD_W  operand of sigma1
//                sigma0 out WORD_W  sigma0(x0)
//                sigma1 out WORD_W  sigma1(x1)
//  Revision    : 1.0 - initial release
// ============================================================================
module sha_sigma
    import sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    output logic [WORD_W-1:0] sigma0,
    output logic [WORD_W-1:0] sigma1
);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    generate
        if (WORD_W == 64) begin : g_sha512
            assign sigma0 = rotr(x0, S512_S0_ROT_A) ^ rotr(x0, S512_S0_ROT_B) ^ (x0 >> S512_S0_SHR);
            assign sigma1 = rotr(x1, S512_S1_ROT_A) ^ rotr(x1, S512_S1_ROT_B) ^ (x1 >> S512_S1_SHR);
        end else begin : g_sha256
            assign sigma0 = rotr(x0, S256_S0_ROT_A) ^ rotr(x0, S256_S0_ROT_B) ^ (x0 >> S256_S0_SHR);
            assign sigma1 = rotr(x1, S256_S1_ROT_A) ^ rotr(x1, S256_S1_ROT_B) ^ (x1 >> S256_S1_SHR);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/msg_schedule_stream.sv
`default_nettype none
// ============================================================================
//  Module      : msg_schedule_stream
//  Description : Streams the SHA-2 message schedule W[0..ROUNDS-1] for one
//                padded 16-word block at a time, one word per handshake,
//                using a 16-word sliding window.
//  Config macro: MSG_SCHED_PRELOAD_EN - adds a one-block pending buffer so
//                consecutive blocks stream with no idle cycle between them.
//  Ports       : clk        in   1          clock, rising edge
//                rst        in   1          asynchronous active-high reset
//                blk_valid  in   1          padded block offered
//                blk_ready  out  1          block accepted when blk_valid high
//                blk_data   in   16*WORD_W  block, MSB-most word is W[0]
//                w_valid    out  1          schedule word present
//                w_ready    in   1          consumer takes the word
//                w_data     out  WORD_W     schedule word W[t]
//                w_idx      out  7          round index t
//                w_last     out  1          t == ROUNDS-1
//                busy       out  1          FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_schedule_stream
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [16*WORD_W-1:0]   blk_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [WORD_W-1:0]      w_data,
    output logic [IDX_W-1:0]       w_idx,
    output logic                   w_last,
    output logic                   busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    sched_state_t          state;
    sched_state_t          state_nxt;
    logic [WORD_W-1:0]     win [16];
    logic [IDX_W-1:0]      t;
    logic [WORD_W-1:0]     s0;
    logic [WORD_W-1:0]     s1;
    logic [WORD_W-1:0]     new_word;
    logic                  hs;
    logic                  last_hs;
    logic                  blk_acc;
    logic                  load_win;
    logic [16*WORD_W-1:0]  load_data;

    // ------------------------------------------------------------------
    // Output and handshake decode
    // ------------------------------------------------------------------
    assign w_valid  = (state == ST_STREAM);
    assign busy     = (state != ST_IDLE);
    assign w_data   = win[0];
    assign w_idx    = t;
    assign w_last   = w_valid && (t == LAST_IDX);
    assign hs       = w_valid && w_ready;
    assign last_hs  = hs && (t == LAST_IDX);
    assign blk_acc  = blk_valid && blk_ready;

`ifdef MSG_SCHED_PRELOAD_EN
    logic                  pend_valid;
    logic [16*WORD_W-1:0]  pend_data;
    logic                  pend_fill;
    logic                  pend_take;

    assign blk_ready = !pend_valid;
`else
    assign blk_ready = (state == ST_IDLE);
`endif

    // ------------------------------------------------------------------
    // Next schedule word: W[t+16] from the window holding W[t..t+15]
    // ------------------------------------------------------------------
    sha_sigma #(
        .WORD_W (WORD_W)
    ) u_sigma (
        .x0     (win[1]),
        .x1     (win[14]),
        .sigma0 (s0),
        .sigma1 (s1)
    );

    assign new_word = s1 + win[9] + s0 + win[0];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and window-load decision
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        load_data = blk_data;
`ifdef MSG_SCHED_PRELOAD_EN
        pend_fill = 1'b0;
        pend_take = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (blk_acc) begin
                    load_win  = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
`ifdef MSG_SCHED_PRELOAD_EN
                if (last_hs) begin
                    // Chain straight into the next block when one is waiting
                    // (buffered, or arriving on this very cycle).
                    if (pend_valid) begin
                        load_win  = 1'b1;
                        load_data = pend_data;
                        pend_take = 1'b1;
                    end else if (blk_acc) begin
                        load_win  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (blk_acc) begin
                    pend_fill = 1'b1;
                end
`else
                if (last_hs) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Window, round counter and pending buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            t <= '0;
        end else if (load_win) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= load_data[(15-i)*WORD_W +: WORD_W];
            end
            t <= '0;
        end else if (hs) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= new_word;
            // Wrap to 0 at the end of a block so an idle streamer reads t=0
            t <= last_hs ? '0 : t + 1'b1;
        end
    end

`ifdef MSG_SCHED_PRELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (pend_take) begin
            pend_valid <= 1'b0;
        end else if (pend_fill) begin
            pend_valid <= 1'b1;
            pend_data  <= blk_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/msg_schedule_stream.md
MSG_SCHEDULE_STREAM -- requirements
Module: msg_schedule_stream

Interface
REQ-001 SHALL have parameter WORD_W, default 32, message word width; legal values are 32 (SHA-256) and 64 (SHA-512).
REQ-002 SHALL have parameter ROUNDS, default 64, number of schedule words emitted per block; legal values are 64 (WORD_W=32) and 80 (WORD_W=64).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port blk_valid  in  1  padded block offered.
REQ-006 SHALL have port blk_ready  out  1  block accepted when blk_valid is also high.
REQ-007 SHALL have port blk_data  in  16*WORD_W  block; MSB-most word is W[0], LSB-most word is W[15].
REQ-008 SHALL have port w_valid  out  1  schedule word present.
REQ-009 SHALL have port w_ready  in  1  consumer takes word when w_valid is also high.
REQ-010 SHALL have port w_data  out  WORD_W  schedule word W[t].
REQ-011 SHALL have port w_idx  out  7  round index t.
REQ-012 SHALL have port w_last  out  1  high when t = ROUNDS-1.
REQ-013 SHALL have port busy  out  1  high when state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and STREAM.
REQ-015 SHALL hold a 16-word sliding window win[0..15] containing W[t..t+15]; win[0] drives w_data.
REQ-016 In IDLE, a blk_valid&&blk_ready cycle SHALL load the window from blk_data, set t=0 and enter STREAM; w_valid SHALL rise on the next cycle (1-cycle latency).
REQ-017 On each w_valid&&w_ready handshake, the window SHALL shift down by one word and win[15] SHALL receive sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], summed modulo 2^WORD_W; t SHALL increment.
REQ-018 For WORD_W=32, sigma0 SHALL be ROTR7^ROTR18^SHR3 and sigma1 SHALL be ROTR17^ROTR19^SHR10; for WORD_W=64, sigma0 SHALL be ROTR1^ROTR8^SHR7 and sigma1 SHALL be ROTR19^ROTR61^SHR6.
REQ-019 While w_valid && !w_ready, w_data, w_idx, w_last and the window SHALL hold stable.
REQ-020 On the handshake with t=ROUNDS-1, the FSM SHALL return to IDLE and w_valid SHALL drop on the next cycle, unless REQ-027 applies.
REQ-021 blk_ready SHALL be combinational from state/buffer status only, never from blk_valid.
REQ-022 Words computed beyond W[ROUNDS-1] SHALL never be emitted.

Reset
REQ-023 Assertion of rst SHALL immediately force IDLE, t=0, window to zero, and any pending buffer to empty.
REQ-024 During and after reset, outputs SHALL be w_valid=0, w_last=0, w_data=0, w_idx=0, busy=0, blk_ready=1.
REQ-025 rst asserted mid-block SHALL discard the block with no further w_valid; release SHALL resume in IDLE.

Configuration
REQ-026 Without MSG_SCHED_PRELOAD_EN: blk_ready SHALL equal (state==IDLE), giving a minimum of one idle cycle between the last word of a block and W[0] of the next.
REQ-027 With MSG_SCHED_PRELOAD_EN: a one-block pending buffer SHALL be present, and blk_ready SHALL equal (pending empty). In STREAM, an accepted block SHALL go to the pending buffer. At the last-word handshake with pending full, or with a block accepted in that same cycle, that block SHALL load the window, t SHALL reset to 0, and the FSM SHALL stay in STREAM with w_valid continuously high (zero bubble).

Structure
REQ-028 Package sha_pkg SHALL hold the FSM state enum, the legal WORD_W/ROUNDS pairs, and the sigma rotate/shift constants per word width.
REQ-029 Sub-module sha_sigma (WORD_W parameter, combinational sigma0/sigma1) SHALL be instantiated once.

Verification
REQ-030 SHA-256 "abc" block (0x61626380, 14 zero words, 0x00000018) with w_ready=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB with w_last=1, exactly 64 handshakes.
REQ-031 Same block, w_ready toggled randomly -> identical word sequence, and outputs stable on every stall cycle.
REQ-032 rst pulsed after the W[20] handshake -> w_valid=0 at once; a fresh "abc" block then yields W[0]=0x61626380 at w_idx=0.
REQ-033 Two back-to-back blocks with the macro defined -> 128 consecutive w_valid cycles with no gap; without the macro -> exactly one w_valid=0 cycle between the blocks.
REQ-034 WORD_W=64, ROUNDS=80, SHA-512 "abc" block (W[0]=0x6162638000000000, W[15]=0x18) -> W[16]=0x6162638000000000, 80 words, w_last only at w_idx=79.
